// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter sharing the FTDI TX byte path between N_SRC sources.
// Each granted burst (at most MAX_BURST bytes) is preceded by a header byte HDR_BASE | source index.
module ftdi_tx_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter logic [7:0]  HDR_BASE  = 8'hC0
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [N_SRC-1:0]     src_last,
  input  logic [8*N_SRC-1:0]   src_data,
  output logic [N_SRC-1:0]     src_ready,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [3:0]           grant_id
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  state_t     state, state_next;
  logic [3:0] rr_ptr;
  logic [7:0] burst_cnt;
  logic [7:0] cnt_inc;
  logic [15:0] valid_pad, last_pad;
  logic [7:0] data_arr [16];
  logic       any_req;
  logic [3:0] pick, cand;
  logic       xfer, burst_end;

  // Pad per-source inputs to 16 entries so the 4-bit grant_id indexes them directly.
  for (genvar g = 0; g < 16; g++) begin : g_pad
    if (g < N_SRC) begin : g_used
      assign valid_pad[g]  = src_valid[g];
      assign last_pad[g]   = src_last[g];
      assign data_arr[g]   = src_data[g*8 +: 8];
      assign src_ready[g]  = (state == ST_DATA) && (grant_id == 4'(g)) && tx_ready;
    end else begin : g_unused
      assign valid_pad[g]  = 1'b0;
      assign last_pad[g]   = 1'b0;
      assign data_arr[g]   = '0;
    end
  end

  // Scan from rr_ptr+1 upward, wrapping modulo N_SRC (not a power-of-two wrap).
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      cand = 4'((32'(rr_ptr) + off) % N_SRC);
      if (!any_req && valid_pad[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign xfer      = tx_valid && tx_ready;
  assign cnt_inc   = burst_cnt + 8'd1;
  assign burst_end = last_pad[grant_id] || (cnt_inc == 8'(MAX_BURST));
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clock_in) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_req)           state_next = ST_HDR;
      ST_HDR:  if (xfer)              state_next = ST_DATA;
      ST_DATA: if (xfer && burst_end) state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state)
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BASE | {4'h0, grant_id};
      end
      ST_DATA: begin
        tx_valid = valid_pad[grant_id];
        tx_data  = data_arr[grant_id];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      grant_id  <= '0;
      rr_ptr    <= 4'(N_SRC - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          grant_id <= pick;
          rr_ptr   <= pick;
        end
        ST_HDR:  if (xfer) burst_cnt <= '0;
        ST_DATA: if (xfer) burst_cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed bench for ftdi_tx_arbiter (N_SRC=4, MAX_BURST=4): byte k of source s is {s,k+1}.
module tb_ftdi_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  src_valid, src_last, src_ready;
  logic [31:0] src_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        busy;
  logic [3:0]  grant_id;

  ftdi_tx_arbiter #(.N_SRC(4), .MAX_BURST(4), .HDR_BASE(8'hC0)) dut (
    .clock_in (clk),
    .reset    (reset),
    .src_valid(src_valid),
    .src_last (src_last),
    .src_data (src_data),
    .src_ready(src_ready),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    logic [15:0] lens;    // {len3,len2,len1,len0}
    logic [95:0] stream;  // expected tx bytes, first byte most significant
    int          n;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] lens = '0;
  logic [15:0] new_lens = '0;
  logic        load = 1'b0;
  logic [3:0]  hold = '0;
  logic [3:0]  took = '0;
  int          src_pos[4] = '{0, 0, 0, 0};
  int          rdy_cnt[4] = '{0, 0, 0, 0};
  logic [7:0]  got[$];
  int          tests = 0;
  int          fails = 0;

  // Source model: each source streams len bytes, last flagged on the final one.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_valid[i]       = (src_pos[i] < int'(lens[i*4 +: 4])) && !hold[i];
      src_last[i]        = (src_pos[i] == int'(lens[i*4 +: 4]) - 1);
      src_data[i*8 +: 8] = 8'((i << 4) | (src_pos[i] + 1));
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      took[i] = src_valid[i] && src_ready[i];
      if (src_ready[i]) rdy_cnt[i]++;
    end
    if (tx_valid && tx_ready) got.push_back(tx_data);
  end

  always @(posedge clk) begin
    if (load) begin
      lens <= new_lens;
      for (int i = 0; i < 4; i++) src_pos[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) if (took[i]) src_pos[i] <= src_pos[i] + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_src(input logic [15:0] l);
    new_lens = l;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic clear_mon();
    got.delete();
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < 300; c++) begin
      if (got.size() >= n && !busy) break;
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic check_stream(input string nm, input logic [95:0] s, input int n);
    logic [31:0] act;
    check({nm, "_count"}, got.size(), n);
    for (int k = 0; k < n; k++) begin
      act = (k < got.size()) ? {24'h0, got[k]} : 32'hDEADBEEF;
      check($sformatf("%s_byte%0d", nm, k), act, {24'h0, s[8*(n-1-k) +: 8]});
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic       prev_stall;
    logic [7:0] prev_data;

    vecs[0] = '{name:"single",    rst:1'b1, lens:16'h0200, stream:96'hC22122,             n:3};
    vecs[1] = '{name:"contend",   rst:1'b1, lens:16'h1011, stream:96'hC001C111C331,       n:6};
    vecs[2] = '{name:"wrap",      rst:1'b0, lens:16'h0101, stream:96'hC001C221,           n:4};
    vecs[3] = '{name:"cap",       rst:1'b1, lens:16'h0060, stream:96'hC111121314C11516,   n:8};
    vecs[4] = '{name:"cap_fair",  rst:1'b1, lens:16'h0015, stream:96'hC001020304C111C005, n:9};
    vecs[5] = '{name:"exact_cap", rst:1'b1, lens:16'h4000, stream:96'hC331323334,         n:5};
    vecs[6] = '{name:"all4",      rst:1'b1, lens:16'h1121, stream:96'hC001C11112C221C331, n:9};

    tick();
    tick();
    check("reset_state", {27'h0, busy, tx_valid, src_ready}, 32'h0);
    check("reset_grant", {28'h0, grant_id}, 32'h0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst) do_reset();
      clear_mon();
      load_src(vecs[v].lens);
      drain(vecs[v].n);
      check_stream(vecs[v].name, vecs[v].stream, vecs[v].n);
      check({vecs[v].name, "_idle"}, {31'h0, busy}, 32'h0);
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_src_ready%0d", vecs[v].name, i), rdy_cnt[i],
              {28'h0, vecs[v].lens[i*4 +: 4]});
    end

    // Backpressure: tx_ready cycles 1,0,0,1 while source 1 sends two bytes.
    pat = 4'b1001;
    do_reset();
    clear_mon();
    load_src(16'h0020);
    prev_stall = 1'b0;
    prev_data  = '0;
    tx_ready   = pat[0];
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("bp_hold_valid", {31'h0, tx_valid}, 32'h1);
        check("bp_hold_data", {24'h0, tx_data}, {24'h0, prev_data});
      end
      if (tx_valid)
        check("bp_src_ready", {31'h0, src_ready[1]},
              {31'h0, (tx_data == 8'hC1) ? 1'b0 : tx_ready});
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      tick();
      tx_ready = pat[(c + 1) % 4];
      if (got.size() >= 3 && !busy) break;
    end
    tx_ready = 1'b1;
    repeat (4) tick();
    check_stream("bp", 96'hC11112, 3);

    // Stall after the first of three bytes, then reset mid-burst.
    do_reset();
    clear_mon();
    load_src(16'h0003);
    for (int c = 0; c < 50; c++) begin
      if (src_pos[0] >= 1) break;
      tick();
    end
    hold[0] = 1'b1;
    check("stall_reached", src_pos[0], 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_hold", {26'h0, busy, tx_valid, grant_id}, 32'h20);
    end
    tick();
    do_reset();
    @(negedge clk);
    check("stall_reset", {23'h0, busy, tx_valid, grant_id, src_ready}, 32'h0);
    tick();
    got.delete();
    hold[0] = 1'b0;
    drain(3);
    check_stream("restart", 96'hC00203, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
